branch_redirect_ctrl: RTL
=========================

// Module: branch_redirect_ctrl
// PURPOSE
//  Drives the IF_stage redirect inputs (branch_addr/branch_taken, jump_addr/is_jump) from the decode side.
//  Evaluates the branch condition and computes the target. Holds the redirect level until IF consumes it
//  at a fetch slot, then squashes the wrong-path instruction in decode.
//  Sits between the ID stage and IF_stage.
// PARAMETERS
//  PC_W           `PC_WIDTH  width of PC/word addresses (from lapido_defs.v)
//  OFS_W          16         width of signed branch offset field
//  SQUASH_CYCLES  1          cycles flush_id stays high after IF accepts a redirect (>=1)
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  id_valid      in   1      decode holds a real (non-NOP) instruction this cycle
//  id_is_branch  in   1      decoded conditional branch
//  id_is_jump    in   1      decoded unconditional jump
//  id_cond       in   3      condition select, `COND_* codes
//  flags         in   4      {Z,N,C,V} from flag register
//  id_offset     in   OFS_W  signed word offset, relative to id_next_pc
//  id_next_pc    in   PC_W   PC+1 of the instruction in decode
//  id_jump_tgt   in   PC_W   absolute jump target
//  if_enable     in   1      IF fetch slot (IF counter write-PC point); high = IF samples redirect this edge
//  branch_addr   out  PC_W   to IF_stage
//  branch_taken  out  1      to IF_stage, level
//  jump_addr     out  PC_W   to IF_stage
//  is_jump       out  1      to IF_stage, level
//  flush_id      out  1      replace decode contents with `NOP_INSTRUCTION
//  busy          out  1      redirect pending; decode must stall new control-flow instructions
// BEHAVIOUR
//  - Reset (async, any time incl. mid-redirect): state IDLE; all outputs 0, addresses 0.
//  - All outputs registered. Capture at an edge gives outputs visible the following cycle.
//  - Condition codes (id_cond): 0 always, 1 Z, 2 !Z, 3 N, 4 !N, 5 C, 6 V, 7 N^V.
//  - Target: branch_addr = id_next_pc + sign_ext(id_offset), truncated mod 2^PC_W.
//    Wrap-around is silent. jump_addr = id_jump_tgt.
//  - FSM IDLE -> HOLD -> SQUASH -> IDLE:
//    IDLE:   at edge with id_valid & id_is_jump -> load jump_addr, is_jump=1, go HOLD.
//            else at edge with id_valid & id_is_branch & cond true -> load branch_addr, branch_taken=1, go HOLD.
//            Branch not taken -> no output change, stay IDLE.
//            Jump and branch both high -> jump wins.
//    HOLD:   redirect level and address held stable; flush_id=1.
//            At edge with if_enable=1 -> clear branch_taken/is_jump, load counter, go SQUASH.
//            if_enable high in the same cycle HOLD is entered counts as acceptance at that edge.
//    SQUASH: flush_id=1 for SQUASH_CYCLES cycles, redirect outputs 0 -> IDLE.
//            Redirect deasserted for at least one cycle between redirects, as IF requires.
//  - busy = (state != IDLE). Control-flow inputs arriving while busy are ignored, not queued.
//  - Addresses keep their last value when the redirect drops; only the level signals return to 0.
//  - branch_taken and is_jump are never high together.
// STRUCTURE
//  - lapido_defs.v gains `COND_ALWAYS..`COND_LT (3-bit), `RDR_IDLE/`RDR_HOLD/`RDR_SQUASH state codes;
//    reuses `PC_WIDTH and `NOP_INSTRUCTION.
//  - One sub-module: cond_eval (combinational id_cond x flags -> taken). Keeps it reusable by the EX stage.
//  - Top: FSM, squash counter, target adder, output registers.
// TESTING
//  - Reset: rst=1 mid-HOLD with branch_taken=1 -> same cycle all outputs 0. After release: IDLE, busy=0.
//  - Jump: id_jump_tgt=5, if_enable low 3 cycles then high -> is_jump=1, jump_addr=5 held 4 cycles.
//    Then 0, flush_id for 1 more cycle.
//  - Taken branch: id_next_pc=3, id_offset=-2, cond=1, Z=1 -> branch_addr=1, branch_taken=1 until if_enable edge.
//  - Not taken: cond=2, Z=1 -> branch_taken stays 0, busy 0, flush_id 0.
//  - Wrap: PC_W=8, id_next_pc=8'hFE, id_offset=+4 -> branch_addr=8'h02.
//  - Collision: id_is_jump & id_is_branch together -> only is_jump asserted.
//    Second branch while busy -> ignored.
//    Back-to-back redirects show >=1 cycle gap in branch_taken.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the decode-side redirect controller: condition codes,
// flag bit positions and the redirect FSM state type.
package branch_redirect_ctrl_pkg;

    localparam int DEF_PC_W = 16;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_EQ     = 3'd1;
    localparam logic [2:0] COND_NE     = 3'd2;
    localparam logic [2:0] COND_MI     = 3'd3;
    localparam logic [2:0] COND_PL     = 3'd4;
    localparam logic [2:0] COND_CS     = 3'd5;
    localparam logic [2:0] COND_VS     = 3'd6;
    localparam logic [2:0] COND_LT     = 3'd7;

    // flags bus is {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        RDR_IDLE   = 2'd0,
        RDR_HOLD   = 2'd1,
        RDR_SQUASH = 2'd2
    } rdr_state_e;

    function automatic logic signed_lt(input logic [3:0] flags);
        return flags[FLAG_N] ^ flags[FLAG_V];
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_cond_eval.sv
// Combinational branch-condition evaluator (condition code x {Z,N,C,V} -> taken).
// Kept standalone so the EX stage can reuse it.
module cond_eval
    import branch_redirect_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    // Decode the condition code against the current flags.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_EQ:     taken = flags[FLAG_Z];
            COND_NE:     taken = ~flags[FLAG_Z];
            COND_MI:     taken = flags[FLAG_N];
            COND_PL:     taken = ~flags[FLAG_N];
            COND_CS:     taken = flags[FLAG_C];
            COND_VS:     taken = flags[FLAG_V];
            COND_LT:     taken = signed_lt(flags);
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Decode-side redirect controller: resolves branches/jumps, holds the redirect
// level for IF until a fetch slot accepts it, then squashes the wrong-path decode.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int PC_W          = DEF_PC_W,
    parameter int OFS_W         = 16,
    parameter int SQUASH_CYCLES = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_is_jump,
    input  logic [2:0]       id_cond,
    input  logic [3:0]       flags,
    input  logic [OFS_W-1:0] id_offset,
    input  logic [PC_W-1:0]  id_next_pc,
    input  logic [PC_W-1:0]  id_jump_tgt,
    input  logic             if_enable,
    output logic [PC_W-1:0]  branch_addr,
    output logic             branch_taken,
    output logic [PC_W-1:0]  jump_addr,
    output logic             is_jump,
    output logic             flush_id,
    output logic             busy
);

    localparam int CNT_W = $clog2(SQUASH_CYCLES + 1);

    rdr_state_e        state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [PC_W-1:0]   branch_addr_r, branch_addr_s;
    logic [PC_W-1:0]   jump_addr_r, jump_addr_s;
    logic              branch_taken_r, branch_taken_s;
    logic              is_jump_r, is_jump_s;
    logic              flush_r, flush_s;
    logic              busy_r, busy_s;
    logic              cond_taken_s;
    logic [PC_W-1:0]   ofs_ext_s;
    logic [PC_W-1:0]   target_s;

    cond_eval u_cond_eval (
        .cond  (id_cond),
        .flags (flags),
        .taken (cond_taken_s)
    );

    // Wrap-around of the target is intentional: IF works modulo the PC width.
    assign ofs_ext_s = PC_W'($signed(id_offset));
    assign target_s  = id_next_pc + ofs_ext_s;

    // Next-state and next-output logic for the redirect FSM.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        branch_addr_s  = branch_addr_r;
        jump_addr_s    = jump_addr_r;
        branch_taken_s = branch_taken_r;
        is_jump_s      = is_jump_r;
        flush_s        = flush_r;
        case (state_r)
            RDR_IDLE: begin
                if (id_valid && id_is_jump) begin
                    jump_addr_s    = id_jump_tgt;
                    is_jump_s      = 1'b1;
                    branch_taken_s = 1'b0;
                    flush_s        = 1'b1;
                    state_s        = RDR_HOLD;
                end else if (id_valid && id_is_branch && cond_taken_s) begin
                    branch_addr_s  = target_s;
                    branch_taken_s = 1'b1;
                    is_jump_s      = 1'b0;
                    flush_s        = 1'b1;
                    state_s        = RDR_HOLD;
                end else begin
                    state_s        = RDR_IDLE;
                end
            end
            RDR_HOLD: begin
                if (if_enable) begin
                    branch_taken_s = 1'b0;
                    is_jump_s      = 1'b0;
                    cnt_s          = CNT_W'(SQUASH_CYCLES - 1);
                    state_s        = RDR_SQUASH;
                end else begin
                    state_s        = RDR_HOLD;
                end
            end
            RDR_SQUASH: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    flush_s = 1'b0;
                    state_s = RDR_IDLE;
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    state_s = RDR_SQUASH;
                end
            end
            default: begin
                branch_taken_s = 1'b0;
                is_jump_s      = 1'b0;
                flush_s        = 1'b0;
                cnt_s          = {CNT_W{1'b0}};
                state_s        = RDR_IDLE;
            end
        endcase
        busy_s = (state_s != RDR_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= RDR_IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            branch_addr_r  <= {PC_W{1'b0}};
            jump_addr_r    <= {PC_W{1'b0}};
            branch_taken_r <= 1'b0;
            is_jump_r      <= 1'b0;
            flush_r        <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            branch_addr_r  <= branch_addr_s;
            jump_addr_r    <= jump_addr_s;
            branch_taken_r <= branch_taken_s;
            is_jump_r      <= is_jump_s;
            flush_r        <= flush_s;
            busy_r         <= busy_s;
        end
    end

    assign branch_addr  = branch_addr_r;
    assign branch_taken = branch_taken_r;
    assign jump_addr    = jump_addr_r;
    assign is_jump      = is_jump_r;
    assign flush_id     = flush_r;
    assign busy         = busy_r;

endmodule
